// File: rtl/alu_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_if
//  Description : ALU -> writeback bundle. Carries the valid/ready handshake,
//                the ALU result with its side information, and returns the
//                committed carry to the ALU as its carry-in.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_writeback_if #(
   parameter int DATA_W = 8
);
   logic              alu_valid;
   logic              alu_ready;
   logic [DATA_W-1:0] alu_out;
   logic              alu_co;
   logic              alu_hc;
   logic [2:0]        alu_op;
   logic              opnd_r7;
   logic              opnd_m7;
   logic [1:0]        dst_sel;
   logic              flag_we;
   logic              decimal_mode;
   logic              carry_to_alu;

   // ALU side: produces results, sees back-pressure and the committed carry
   modport master (
      output alu_valid, alu_out, alu_co, alu_hc, alu_op,
             opnd_r7, opnd_m7, dst_sel, flag_we, decimal_mode,
      input  alu_ready, carry_to_alu
   );

   // Writeback side: consumes results, drives back-pressure and carry
   modport slave (
      input  alu_valid, alu_out, alu_co, alu_hc, alu_op,
             opnd_r7, opnd_m7, dst_sel, flag_we, decimal_mode,
      output alu_ready, carry_to_alu
   );
endinterface
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback
//  Description : Writeback stage of the 8-bit ALU. Captures one ALU result
//                per handshake, commits it to A/X/Y and updates N/Z/C/V.
//                Flag C is fed back to the ALU as its carry-in.
//                Optional feature macro: DECIMAL_ADJUST_EN
//                  defined   -> ADC/SBC with decimal_mode=1 pass through an
//                               ADJUST state applying BCD correction
//                               (latency 3 instead of 2).
//                  undefined -> decimal_mode ignored, latency always 2.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_writeback #(
   parameter int DATA_W = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   alu_writeback_if.slave         bus,
   output logic [DATA_W-1:0]      reg_a_o,
   output logic [DATA_W-1:0]      reg_x_o,
   output logic [DATA_W-1:0]      reg_y_o,
   output logic                   flag_n_o,
   output logic                   flag_z_o,
   output logic                   flag_c_o,
   output logic                   flag_v_o,
   output logic                   wb_done_o
);

   // ------------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_COMMIT = 2'd1;
`ifdef DECIMAL_ADJUST_EN
   localparam logic [1:0] ST_ADJUST = 2'd2;
`endif

   localparam logic [2:0] OP_OR  = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_EOR = 3'b010;
   localparam logic [2:0] OP_ADC = 3'b011;
   localparam logic [2:0] OP_INC = 3'b100;
   localparam logic [2:0] OP_DEC = 3'b101;
   localparam logic [2:0] OP_SBC = 3'b110;
   localparam logic [2:0] OP_TRB = 3'b111;

   localparam logic [1:0] DST_A    = 2'b00;
   localparam logic [1:0] DST_X    = 2'b01;
   localparam logic [1:0] DST_Y    = 2'b10;

   localparam int MSB = DATA_W - 1;

   // ------------------------------------------------------------------------
   // State and holding registers
   // ------------------------------------------------------------------------
   logic [1:0]        state_q, state_d;

   logic [DATA_W-1:0] res_q;      // result (BCD-adjusted after ADJUST)
   logic              co_q;       // carry (BCD-adjusted after ADJUST)
   logic              bin7_q;     // binary result MSB, V always uses this
   logic [2:0]        op_q;
   logic              r7_q;
   logic              m7_q;
   logic [1:0]        dst_q;
   logic              we_q;
`ifdef DECIMAL_ADJUST_EN
   logic              hc_q;
`endif

   logic [DATA_W-1:0] reg_a_q, reg_a_d;
   logic [DATA_W-1:0] reg_x_q, reg_x_d;
   logic [DATA_W-1:0] reg_y_q, reg_y_d;
   logic              flag_n_q, flag_n_d;
   logic              flag_z_q, flag_z_d;
   logic              flag_c_q, flag_c_d;
   logic              flag_v_q, flag_v_d;
   logic              wb_done_q;

   logic              w_ready;
   logic              w_commit;
   logic              w_accept;
   logic              w_go_adjust;

   assign w_accept = bus.alu_valid & w_ready;

`ifdef DECIMAL_ADJUST_EN
   logic              w_adjust;
   logic [DATA_W-1:0] w_adj_res;
   logic              w_adj_c;

   // Decimal correction is requested only for ADC/SBC with the D flag set
   assign w_go_adjust = bus.decimal_mode &
                        ((bus.alu_op == OP_ADC) || (bus.alu_op == OP_SBC));
`else
   logic              w_unused_dec;

   // Decimal mode and half carry have no effect in a binary-only build
   assign w_go_adjust  = 1'b0;
   assign w_unused_dec = bus.decimal_mode ^ bus.alu_hc;
`endif

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------

   // State register; reset abandons any captured transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept -> (ADJUST ->) COMMIT -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef DECIMAL_ADJUST_EN
               state_d = w_go_adjust ? ST_ADJUST : ST_COMMIT;
`else
               state_d = w_go_adjust ? ST_IDLE : ST_COMMIT;
`endif
            end
         end
`ifdef DECIMAL_ADJUST_EN
         ST_ADJUST: state_d = ST_COMMIT;
`endif
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: back-pressure and per-state strobes
   always_comb begin
      w_ready  = (state_q == ST_IDLE);
      w_commit = (state_q == ST_COMMIT);
`ifdef DECIMAL_ADJUST_EN
      w_adjust = (state_q == ST_ADJUST);
`endif
   end

   // ------------------------------------------------------------------------
   // BCD correction of the held binary result
   // ------------------------------------------------------------------------
`ifdef DECIMAL_ADJUST_EN
   // ADC adds 0x06/0x60 and may force carry; SBC subtracts on missing borrows
   always_comb begin
      w_adj_res = res_q;
      w_adj_c   = co_q;
      if (op_q == OP_ADC) begin
         if (hc_q || (res_q[3:0] > 4'd9)) begin
            w_adj_res = w_adj_res + DATA_W'(8'h06);
         end
         if (co_q || (res_q > DATA_W'(8'h99))) begin
            w_adj_res = w_adj_res + DATA_W'(8'h60);
            w_adj_c   = 1'b1;
         end
      end else begin
         if (!hc_q) begin
            w_adj_res = w_adj_res - DATA_W'(8'h06);
         end
         if (!co_q) begin
            w_adj_res = w_adj_res - DATA_W'(8'h60);
         end
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Holding registers
   // ------------------------------------------------------------------------

   // Capture inputs at accept; ADJUST overwrites result/carry in place
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q  <= '0;
         co_q   <= 1'b0;
         bin7_q <= 1'b0;
         op_q   <= OP_OR;
         r7_q   <= 1'b0;
         m7_q   <= 1'b0;
         dst_q  <= DST_A;
         we_q   <= 1'b0;
`ifdef DECIMAL_ADJUST_EN
         hc_q   <= 1'b0;
`endif
      end else if (w_accept) begin
         res_q  <= bus.alu_out;
         co_q   <= bus.alu_co;
         bin7_q <= bus.alu_out[MSB];
         op_q   <= bus.alu_op;
         r7_q   <= bus.opnd_r7;
         m7_q   <= bus.opnd_m7;
         dst_q  <= bus.dst_sel;
         we_q   <= bus.flag_we;
`ifdef DECIMAL_ADJUST_EN
         hc_q   <= bus.alu_hc;
`endif
      end
`ifdef DECIMAL_ADJUST_EN
      else if (w_adjust) begin
         res_q  <= w_adj_res;
         co_q   <= w_adj_c;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------------

   // Next values of A/X/Y and N/Z/C/V, only changed in the COMMIT state
   always_comb begin
      reg_a_d  = reg_a_q;
      reg_x_d  = reg_x_q;
      reg_y_d  = reg_y_q;
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
      flag_v_d = flag_v_q;
      if (w_commit) begin
         case (dst_q)
            DST_A:   reg_a_d = res_q;
            DST_X:   reg_x_d = res_q;
            DST_Y:   reg_y_d = res_q;
            default: ;  // compare-style op: flags only
         endcase
         if (we_q) begin
            flag_n_d = res_q[MSB];
            flag_z_d = (res_q == '0);
            case (op_q)
               OP_ADC: begin
                  flag_c_d = co_q;
                  flag_v_d = (r7_q == m7_q) & (bin7_q != r7_q);
               end
               OP_SBC: begin
                  flag_c_d = co_q;
                  flag_v_d = (r7_q != m7_q) & (bin7_q != r7_q);
               end
               OP_INC, OP_DEC: begin
                  flag_c_d = co_q;
               end
               OP_OR, OP_AND, OP_EOR, OP_TRB: ;  // C and V preserved
               default: ;
            endcase
         end
      end
   end

   // Register file, flags and the completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_a_q   <= '0;
         reg_x_q   <= '0;
         reg_y_q   <= '0;
         flag_n_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_v_q  <= 1'b0;
         wb_done_q <= 1'b0;
      end else begin
         reg_a_q   <= reg_a_d;
         reg_x_q   <= reg_x_d;
         reg_y_q   <= reg_y_d;
         flag_n_q  <= flag_n_d;
         flag_z_q  <= flag_z_d;
         flag_c_q  <= flag_c_d;
         flag_v_q  <= flag_v_d;
         wb_done_q <= w_commit;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.alu_ready    = w_ready;
   assign bus.carry_to_alu = flag_c_q;
   assign reg_a_o          = reg_a_q;
   assign reg_x_o          = reg_x_q;
   assign reg_y_o          = reg_y_q;
   assign flag_n_o         = flag_n_q;
   assign flag_z_o         = flag_z_q;
   assign flag_c_o         = flag_c_q;
   assign flag_v_o         = flag_v_q;
   assign wb_done_o        = wb_done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback
//  Description : Directed self-checking bench for alu_writeback.
//                Honours DECIMAL_ADJUST_EN the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_writeback;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] reg_a, reg_x, reg_y;
   logic       flag_n, flag_z, flag_c, flag_v, wb_done;

   int n_checks = 0;
   int n_pass   = 0;

   alu_writeback_if #(.DATA_W(8)) bus ();

   alu_writeback #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .reg_a_o   (reg_a),
      .reg_x_o   (reg_x),
      .reg_y_o   (reg_y),
      .flag_n_o  (flag_n),
      .flag_z_o  (flag_z),
      .flag_c_o  (flag_c),
      .flag_v_o  (flag_v),
      .wb_done_o (wb_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_arch(input string tag, input logic [7:0] a, x, y,
                             input logic n, z, c, v);
      check({tag, "_A"}, {24'd0, reg_a}, {24'd0, a});
      check({tag, "_X"}, {24'd0, reg_x}, {24'd0, x});
      check({tag, "_Y"}, {24'd0, reg_y}, {24'd0, y});
      check({tag, "_NZCV"}, {28'd0, flag_n, flag_z, flag_c, flag_v},
            {28'd0, n, z, c, v});
      check({tag, "_cin"}, {31'd0, bus.carry_to_alu}, {31'd0, c});
   endtask

   task automatic drive(input logic [2:0] op, input logic [7:0] out,
                        input logic co, hc, r7, m7, input logic [1:0] dst,
                        input logic we, dec);
      bus.alu_op       = op;
      bus.alu_out      = out;
      bus.alu_co       = co;
      bus.alu_hc       = hc;
      bus.opnd_r7      = r7;
      bus.opnd_m7      = m7;
      bus.dst_sel      = dst;
      bus.flag_we      = we;
      bus.decimal_mode = dec;
   endtask

   // One transaction from a negedge; checks ready, back-pressure and latency
   task automatic xfer(input string tag, input logic [2:0] op, input logic [7:0] out,
                       input logic co, hc, r7, m7, input logic [1:0] dst,
                       input logic we, dec, input int lat);
      int cyc;
      cyc = 0;
      check({tag, "_ready0"}, {31'd0, bus.alu_ready}, 32'd1);
      drive(op, out, co, hc, r7, m7, dst, we, dec);
      bus.alu_valid = 1'b1;
      do begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            bus.alu_valid = 1'b0;
            drive(~op, ~out, ~co, ~hc, ~r7, ~m7, dst ^ 2'b01, ~we, ~dec);
            check({tag, "_busy"}, {31'd0, bus.alu_ready}, 32'd0);
         end
      end while (!wb_done && cyc < 12);
      check({tag, "_lat"}, cyc, lat);
   endtask

   initial begin
      int lat_dec;
      logic [7:0] b2b [3];
      b2b[0] = 8'h11;
      b2b[1] = 8'h22;
      b2b[2] = 8'h33;
`ifdef DECIMAL_ADJUST_EN
      lat_dec = 3;
`else
      lat_dec = 2;
`endif
      bus.alu_valid = 1'b0;
      drive(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

      // ---- Reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_arch("rst", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
      check("rst_ready", {31'd0, bus.alu_ready}, 32'd1);
      check("rst_done", {31'd0, wb_done}, 32'd0);

      // ---- Reset in the middle of a captured transaction ----
      drive(3'b000, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      bus.alu_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_captured", {31'd0, bus.alu_ready}, 32'd0);
      bus.alu_valid = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("midrst_nodone", {31'd0, wb_done}, 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_arch("midrst", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
      check("midrst_ready", {31'd0, bus.alu_ready}, 32'd1);
      check("midrst_done", {31'd0, wb_done}, 32'd0);

      // ---- ADC binary, overflow into bit 7 ----
      xfer("adc", 3'b011, 8'h80, 0, 0, 0, 0, 2'b00, 1, 0, 2);
      check_arch("adc", 8'h80, 8'h00, 8'h00, 1, 0, 0, 1);
      @(posedge clk);
      @(negedge clk);
      check("adc_pulse", {31'd0, wb_done}, 32'd0);

      // ---- CMP: SBC to no register ----
      xfer("cmp", 3'b110, 8'h00, 1, 0, 0, 0, 2'b11, 1, 0, 2);
      check_arch("cmp", 8'h80, 8'h00, 8'h00, 0, 1, 1, 0);

      // ---- ADC into Y, signed overflow negative+negative ----
      xfer("adcy", 3'b011, 8'h7F, 1, 0, 1, 1, 2'b10, 1, 0, 2);
      check_arch("adcy", 8'h80, 8'h00, 8'h7F, 0, 0, 1, 1);

      // ---- Register write without flag update ----
      xfer("nowe", 3'b000, 8'h55, 0, 0, 0, 0, 2'b01, 0, 0, 2);
      check_arch("nowe", 8'h80, 8'h55, 8'h7F, 0, 0, 1, 1);

      // ---- Logic op: Z set, C and V preserved ----
      xfer("and", 3'b001, 8'h00, 0, 0, 0, 0, 2'b01, 1, 0, 2);
      check_arch("and", 8'h80, 8'h00, 8'h7F, 0, 1, 1, 1);

      // ---- No register, no flags: still completes ----
      xfer("nop", 3'b011, 8'hFF, 0, 0, 1, 0, 2'b11, 0, 0, 2);
      check_arch("nop", 8'h80, 8'h00, 8'h7F, 0, 1, 1, 1);

      // ---- DEC: C cleared from carry out, V preserved ----
      xfer("dec", 3'b101, 8'hFF, 0, 0, 0, 0, 2'b01, 1, 0, 2);
      check_arch("dec", 8'h80, 8'hFF, 8'h7F, 1, 0, 0, 1);

      // ---- Back-to-back with valid held high ----
      bus.alu_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(3'b000, b2b[i], 0, 0, 0, 0, 2'b00, 1, 0);
         check("b2b_ready", {31'd0, bus.alu_ready}, 32'd1);
         @(posedge clk);
         @(negedge clk);
         check("b2b_busy", {31'd0, bus.alu_ready}, 32'd0);
         check("b2b_early", {31'd0, wb_done}, 32'd0);
         drive(3'b011, 8'hEE, 1, 1, 1, 1, 2'b01, 1, 1);
         @(posedge clk);
         @(negedge clk);
         check("b2b_done", {31'd0, wb_done}, 32'd1);
         check("b2b_A", {24'd0, reg_a}, {24'd0, b2b[i]});
      end
      bus.alu_valid = 1'b0;
      check_arch("b2b", 8'h33, 8'hFF, 8'h7F, 0, 0, 0, 1);

      // ---- Decimal mode ADC/SBC (binary when the adjust stage is absent) ----
      xfer("bcd1", 3'b011, 8'h12, 0, 1, 0, 0, 2'b00, 1, 1, lat_dec);
`ifdef DECIMAL_ADJUST_EN
      check_arch("bcd1", 8'h18, 8'hFF, 8'h7F, 0, 0, 0, 0);
`else
      check_arch("bcd1", 8'h12, 8'hFF, 8'h7F, 0, 0, 0, 0);
`endif
      xfer("bcd2", 3'b011, 8'h9A, 0, 0, 1, 0, 2'b00, 1, 1, lat_dec);
`ifdef DECIMAL_ADJUST_EN
      check_arch("bcd2", 8'h00, 8'hFF, 8'h7F, 0, 1, 1, 0);
`else
      check_arch("bcd2", 8'h9A, 8'hFF, 8'h7F, 1, 0, 0, 0);
`endif
      xfer("bcd3", 3'b110, 8'h0F, 1, 0, 0, 0, 2'b10, 1, 1, lat_dec);
`ifdef DECIMAL_ADJUST_EN
      check_arch("bcd3", 8'h00, 8'hFF, 8'h09, 0, 0, 1, 0);
`else
      check_arch("bcd3", 8'h9A, 8'hFF, 8'h0F, 0, 0, 1, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
